// File: rtl/cpu_io_serializer.sv
// Parallel-to-serial feeder for the serial CPU I/O FSM: accepts one A/B/OP frame,
// emits start pulse plus bit stream in fixed slots, then waits for io_done with a timeout.
module cpu_io_serializer #(
    parameter bit MSB_FIRST    = 1'b0,
    parameter int DONE_TIMEOUT = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic [7:0] in_a_i,
    input  logic [7:0] in_b_i,
    input  logic [4:0] in_op_i,
    output logic       fsm_start_o,
    output logic       fsm_bit_o,
    input  logic       io_done_i,
    output logic       busy_o,
    output logic       frame_done_o,
    output logic       timeout_o,
    output logic       err_sticky_o
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        SEND_A,
        GAP_A,
        SEND_B,
        GAP_B,
        SEND_OP,
        WAIT_DONE
    } state_e;

    localparam logic [7:0] TMO_LAST = 8'(DONE_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] tmo_q, tmo_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [4:0] op_q, op_d;
    logic       done_q, done_d;
    logic       tpulse_q, tpulse_d;
    logic       err_q, err_d;

    logic [2:0] idx8;
    logic [2:0] idx5;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            tmo_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            done_q   <= 1'b0;
            tpulse_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            done_q   <= done_d;
            tpulse_q <= tpulse_d;
            err_q    <= err_d;
        end
    end

    // Completion pulses are registered so they appear in the first IDLE cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        done_d   = 1'b0;
        tpulse_d = 1'b0;
        err_d    = err_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (in_valid_i) begin
                    a_d     = in_a_i;
                    b_d     = in_b_i;
                    op_d    = in_op_i;
                    state_d = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = SEND_A;
            end
            SEND_A: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    cnt_d   = '0;
                    state_d = GAP_A;
                end
            end
            GAP_A: begin
                cnt_d   = '0;
                state_d = SEND_B;
            end
            SEND_B: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    cnt_d   = '0;
                    state_d = GAP_B;
                end
            end
            GAP_B: begin
                cnt_d   = '0;
                state_d = SEND_OP;
            end
            SEND_OP: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd4) begin
                    cnt_d   = '0;
                    tmo_d   = '0;
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                tmo_d = tmo_q + 8'd1;
                if (io_done_i) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    tpulse_d = 1'b1;
                    err_d    = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign idx8 = MSB_FIRST ? (3'd7 - cnt_q) : cnt_q;
    assign idx5 = MSB_FIRST ? (3'd4 - cnt_q) : cnt_q;

    always_comb begin
        fsm_bit_o = 1'b0;
        unique case (state_q)
            SEND_A:  fsm_bit_o = a_q[idx8];
            SEND_B:  fsm_bit_o = b_q[idx8];
            SEND_OP: fsm_bit_o = op_q[idx5];
            default: fsm_bit_o = 1'b0;
        endcase
    end

    assign in_ready_o   = (state_q == IDLE) && !rst_i;
    assign fsm_start_o  = (state_q == START);
    assign busy_o       = (state_q != IDLE);
    assign frame_done_o = done_q;
    assign timeout_o    = tpulse_q;
    assign err_sticky_o = err_q;

endmodule

// File: tb/tb_cpu_io_serializer.sv
// Scoreboard bench: an LSB-first and an MSB-first instance share one randomized stimulus;
// a per-instance monitor compares every cycle against a slot-based reference model.
module tb_cpu_io_serializer;

    localparam int TMO     = 8;
    localparam int NRANDOM = 30;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [4:0] op;
        int         acceptCycle;
        int         doneDelay;
        int         spurious;
        int         rstSlot;
    } frame_t;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       inValid = 1'b0;
    logic [7:0] inA     = '0;
    logic [7:0] inB     = '0;
    logic [4:0] inOp    = '0;
    logic       ioDone  = 1'b0;
    logic [1:0] inReady, startO, bitO, busyO, doneO, tmoO, errO;

    int cycle  = 0;
    int checks = 0;
    int errors = 0;
    bit monOn  = 1'b0;

    frame_t q0[$];
    frame_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    cpu_io_serializer #(.MSB_FIRST(1'b0), .DONE_TIMEOUT(TMO)) dutLsb (
        .clk_i(clk), .rst_i(rst), .in_valid_i(inValid), .in_ready_o(inReady[0]),
        .in_a_i(inA), .in_b_i(inB), .in_op_i(inOp),
        .fsm_start_o(startO[0]), .fsm_bit_o(bitO[0]), .io_done_i(ioDone),
        .busy_o(busyO[0]), .frame_done_o(doneO[0]), .timeout_o(tmoO[0]),
        .err_sticky_o(errO[0])
    );

    cpu_io_serializer #(.MSB_FIRST(1'b1), .DONE_TIMEOUT(TMO)) dutMsb (
        .clk_i(clk), .rst_i(rst), .in_valid_i(inValid), .in_ready_o(inReady[1]),
        .in_a_i(inA), .in_b_i(inB), .in_op_i(inOp),
        .fsm_start_o(startO[1]), .fsm_bit_o(bitO[1]), .io_done_i(ioDone),
        .busy_o(busyO[1]), .frame_done_o(doneO[1]), .timeout_o(tmoO[1]),
        .err_sticky_o(errO[1])
    );

    // Expected serial line at slot k after the start cycle: fields with one-cycle gaps.
    function automatic logic streamBit(frame_t f, int k, bit msb);
        if (k >= 1 && k <= 8)   return f.a[msb ? 8 - k : k - 1];
        if (k >= 10 && k <= 17) return f.b[msb ? 17 - k : k - 10];
        if (k >= 19 && k <= 23) return f.op[msb ? 23 - k : k - 19];
        return 1'b0;
    endfunction

    function automatic bit endsByDone(frame_t f);
        return f.doneDelay >= 0 && f.doneDelay < TMO;
    endfunction

    // Offset from the start cycle of the first IDLE cycle after the frame.
    function automatic int endOffset(frame_t f);
        return endsByDone(f) ? 25 + f.doneDelay : 24 + TMO;
    endfunction

    task automatic finishRun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    task automatic checkOutput(input string name, input int d, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s dut%0d cycle %0d: got %0b expected %0b", name, d, cycle, act, exp);
        end
    endtask

    task automatic expectIdle(input int d, input bit errExp);
        checkOutput("idleStart", d, startO[d], 1'b0);
        checkOutput("idleBit",   d, bitO[d],   1'b0);
        checkOutput("idleBusy",  d, busyO[d],  1'b0);
        checkOutput("idleDone",  d, doneO[d],  1'b0);
        checkOutput("idleTmo",   d, tmoO[d],   1'b0);
        checkOutput("idleReady", d, inReady[d], !rst);
        checkOutput("idleErr",   d, errO[d],   errExp);
    endtask

    task automatic monitorDut(input int d);
        frame_t cur;
        bit     active = 1'b0;
        bit     errExp = 1'b0;
        int     s = 0;
        int     k;
        int     endK;
        forever begin
            @(negedge clk);
            if (!active) begin
                if (d == 0 && q0.size() > 0 && q0[0].acceptCycle + 1 == cycle) begin
                    cur = q0.pop_front(); active = 1'b1; s = cycle;
                end else if (d == 1 && q1.size() > 0 && q1[0].acceptCycle + 1 == cycle) begin
                    cur = q1.pop_front(); active = 1'b1; s = cycle;
                end
            end
            if (!active) begin
                expectIdle(d, errExp);
            end else begin
                k = cycle - s;
                if (cur.rstSlot >= 0 && k == cur.rstSlot + 1) begin
                    errExp = 1'b0;
                    expectIdle(d, errExp);
                    active = 1'b0;
                end else if (k <= 23) begin
                    checkOutput("start", d, startO[d], k == 0);
                    checkOutput("bit",   d, bitO[d],   streamBit(cur, k, d == 1));
                    checkOutput("busy",  d, busyO[d],  1'b1);
                    checkOutput("ready", d, inReady[d], 1'b0);
                    checkOutput("done",  d, doneO[d],  1'b0);
                    checkOutput("tmo",   d, tmoO[d],   1'b0);
                    checkOutput("err",   d, errO[d],   errExp);
                end else begin
                    endK = endOffset(cur);
                    if (k < endK) begin
                        checkOutput("waitStart", d, startO[d], 1'b0);
                        checkOutput("waitBit",   d, bitO[d],   1'b0);
                        checkOutput("waitBusy",  d, busyO[d],  1'b1);
                        checkOutput("waitDone",  d, doneO[d],  1'b0);
                        checkOutput("waitTmo",   d, tmoO[d],   1'b0);
                        checkOutput("waitErr",   d, errO[d],   errExp);
                    end else begin
                        if (!endsByDone(cur)) errExp = 1'b1;
                        checkOutput("endStart", d, startO[d], 1'b0);
                        checkOutput("endBit",   d, bitO[d],   1'b0);
                        checkOutput("endBusy",  d, busyO[d],  1'b0);
                        checkOutput("endReady", d, inReady[d], 1'b1);
                        checkOutput("frameDone", d, doneO[d], endsByDone(cur));
                        checkOutput("timeout",  d, tmoO[d],   !endsByDone(cur));
                        checkOutput("endErr",   d, errO[d],   errExp);
                        active = 1'b0;
                    end
                end
            end
        end
    endtask

    // Offers one frame after an idle gap, then drives junk inputs, io_done and reset by slot.
    task automatic applyStimulus(input frame_t f, input int gap);
        int waited = 0;
        int s;
        int last;
        for (int g = 0; g < gap; g++) begin
            inValid = 1'b0; ioDone = 1'b0; rst = 1'b0;
            @(posedge clk); #1;
        end
        inValid = 1'b1; inA = f.a; inB = f.b; inOp = f.op; ioDone = 1'b0; rst = 1'b0;
        @(negedge clk);
        while (!inReady[0] && waited < 64) begin
            @(posedge clk); #1;
            @(negedge clk);
            waited++;
        end
        if (!inReady[0]) begin
            checks++; errors++;
            $display("[TB] FAIL acceptTimeout cycle %0d: got ready 0 expected 1", cycle);
            finishRun();
        end
        f.acceptCycle = cycle;
        q0.push_back(f);
        q1.push_back(f);
        s    = cycle + 1;
        last = (f.rstSlot >= 0) ? s + f.rstSlot : s + endOffset(f) - 1;
        for (int c = s; c <= last; c++) begin
            @(posedge clk); #1;
            inValid = 1'($urandom_range(0, 1));
            inA     = 8'($urandom);
            inB     = 8'($urandom);
            inOp    = 5'($urandom);
            ioDone  = (f.doneDelay >= 0 && c == s + 24 + f.doneDelay) ||
                      (f.spurious >= 0 && c == s + f.spurious);
            rst     = (f.rstSlot >= 0 && c == s + f.rstSlot);
        end
        @(posedge clk); #1;
        inValid = 1'b0; ioDone = 1'b0; rst = 1'b0;
    endtask

    function automatic frame_t mkFrame(logic [7:0] a, logic [7:0] b, logic [4:0] op,
                                       int doneDelay, int spurious, int rstSlot);
        frame_t f;
        f.a = a; f.b = b; f.op = op;
        f.acceptCycle = 0;
        f.doneDelay = doneDelay; f.spurious = spurious; f.rstSlot = rstSlot;
        return f;
    endfunction

    initial begin
        wait (monOn);
        fork
            monitorDut(0);
            monitorDut(1);
        join_none
    end

    initial begin
        #200000;
        checks++; errors++;
        $display("[TB] FAIL watchdog cycle %0d: run did not complete", cycle);
        finishRun();
    end

    initial begin
        frame_t f;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst   = 1'b0;
        monOn = 1'b1;
        @(posedge clk); #1;

        applyStimulus(mkFrame(8'hA5, 8'h3C, 5'h0D, 1, -1, -1), 0);
        applyStimulus(mkFrame(8'hA5, 8'h3C, 5'h0D, 1, -1, -1), 0);
        applyStimulus(mkFrame(8'h5A, 8'hC3, 5'h12, -1, 10, -1), 0);
        applyStimulus(mkFrame(8'h81, 8'h7E, 5'h1F, 3, -1, -1), 1);
        applyStimulus(mkFrame(8'hF0, 8'h0F, 5'h0A, 1, -1, 12), 0);
        applyStimulus(mkFrame(8'hA5, 8'h3C, 5'h0D, 7, -1, -1), 2);
        applyStimulus(mkFrame(8'h33, 8'hCC, 5'h15, 8, -1, -1), 0);

        for (int i = 0; i < NRANDOM; i++) begin
            f = mkFrame(8'($urandom), 8'($urandom), 5'($urandom),
                        int'($urandom_range(0, 9)) - 1,
                        ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 23)) : -1,
                        ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 23)) : -1);
            applyStimulus(f, int'($urandom_range(0, 2)));
        end

        repeat (5) @(posedge clk);
        #1;
        checkOutput("drainLsb", 0, logic'(q0.size() == 0), 1'b1);
        checkOutput("drainMsb", 1, logic'(q1.size() == 0), 1'b1);
        finishRun();
    end

endmodule
